// File: rtl/pmod_serial_tx_pkg.sv
// pmod_serial_tx_pkg: constants and state type shared by the PMOD serial transmitter and receiver.
package pmod_serial_tx_pkg;

    localparam int PMOD_WORD_WIDTH   = 9;
    localparam int PMOD_CLKS_PER_BIT = 2;

    typedef enum logic {
        IDLE,
        SEND
    } pmod_state_t;

endpackage

// File: rtl/pmod_serial_tx_if.sv
// pmod_serial_tx_if: valid/ready word handshake into the PMOD serial transmitter.
interface pmod_serial_tx_if
    import pmod_serial_tx_pkg::*;
#(
    parameter int WIDTH = PMOD_WORD_WIDTH
);

    logic [WIDTH-1:0] i_Data;
    logic             i_Valid;
    logic             o_Ready;

    modport master (output i_Data, output i_Valid, input  o_Ready);
    modport slave  (input  i_Data, input  i_Valid, output o_Ready);

endinterface

// File: rtl/pmod_serial_tx_bit_tick.sv
// pmod_bit_tick: bit-period divider giving first-clock and last-clock ticks of each bit.
module pmod_bit_tick
    import pmod_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = PMOD_CLKS_PER_BIT
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clear,
    output logic o_First,
    output logic o_Last
);

    localparam int            DW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLKS_PER_BIT - 1);

    logic [DW-1:0] r_Div;

    // Count 0..CLKS_PER_BIT-1, held at zero while cleared so a new frame starts on a first tick
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n || i_Clear || r_Div == LAST)
            r_Div <= '0;
        else
            r_Div <= r_Div + 1'b1;
    end

    assign o_First = (r_Div == '0);
    assign o_Last  = (r_Div == LAST);

endmodule

// File: rtl/pmod_serial_tx.sv
// pmod_serial_tx: serializes handshaked words LSB-first on a PMOD pin with frame marker and bit strobe.
module pmod_serial_tx
    import pmod_serial_tx_pkg::*;
#(
    parameter int WIDTH        = PMOD_WORD_WIDTH,
    parameter int CLKS_PER_BIT = PMOD_CLKS_PER_BIT,
    parameter bit REPEAT       = 1'b1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    pmod_serial_tx_if.slave        io_Bus,
    output logic                   o_PMOD_1,
    output logic                   o_PMOD_2,
    output logic                   o_PMOD_3,
    output logic                   o_Frame_Done
);

    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    pmod_state_t      r_State, w_State;
    logic [WIDTH-1:0] r_Shift, w_Shift;
    logic [WIDTH-1:0] r_Held, w_Held;
    logic [WIDTH-1:0] r_Pend, w_Pend;
    logic             r_Pend_Full, w_Pend_Full;
    logic [BW-1:0]    r_Bit, w_Bit;
    logic             w_First, w_Last, w_Accept, w_End, w_Idle;

    assign w_Idle   = (r_State == IDLE);
    assign w_Accept = io_Bus.i_Valid && !r_Pend_Full;
    assign w_End    = !w_Idle && w_Last && (r_Bit == LAST_BIT);

    pmod_bit_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Clear (w_Idle),
        .o_First (w_First),
        .o_Last  (w_Last)
    );

    // State and datapath registers; reset aborts any frame in progress
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_State     <= IDLE;
            r_Shift     <= '0;
            r_Held      <= '0;
            r_Pend      <= '0;
            r_Pend_Full <= 1'b0;
            r_Bit       <= '0;
        end else begin
            r_State     <= w_State;
            r_Shift     <= w_Shift;
            r_Held      <= w_Held;
            r_Pend      <= w_Pend;
            r_Pend_Full <= w_Pend_Full;
            r_Bit       <= w_Bit;
        end
    end

    // Next state: load from idle, shift on bit wrap, pick the next frame at frame end, else buffer into pending
    always_comb begin
        w_State     = r_State;
        w_Shift     = r_Shift;
        w_Held      = r_Held;
        w_Pend      = r_Pend;
        w_Pend_Full = r_Pend_Full;
        w_Bit       = r_Bit;
        if (w_Idle) begin
            if (w_Accept) begin
                w_State = SEND;
                w_Shift = io_Bus.i_Data;
                w_Held  = io_Bus.i_Data;
                w_Bit   = '0;
            end
        end else if (w_End) begin
            w_Bit = '0;
            if (r_Pend_Full) begin
                w_Shift     = r_Pend;
                w_Held      = r_Pend;
                w_Pend_Full = 1'b0;
            end else if (w_Accept) begin
                w_Shift = io_Bus.i_Data;
                w_Held  = io_Bus.i_Data;
            end else if (REPEAT) begin
                w_Shift = r_Held;
            end else begin
                w_State = IDLE;
            end
        end else begin
            if (w_Last) begin
                w_Shift = r_Shift >> 1;
                w_Bit   = r_Bit + 1'b1;
            end
            if (w_Accept) begin
                w_Pend      = io_Bus.i_Data;
                w_Pend_Full = 1'b1;
            end
        end
    end

    assign io_Bus.o_Ready = !r_Pend_Full;
    assign o_PMOD_1       = !w_Idle && r_Shift[0];
    assign o_PMOD_2       = !w_Idle && (r_Bit == '0);
    assign o_PMOD_3       = !w_Idle && w_First;
    assign o_Frame_Done   = w_End;

endmodule

// File: tb/tb_pmod_serial_tx.sv
// tb_pmod_serial_tx: directed checks of the PMOD serial transmitter in three configurations.
module tb_pmod_serial_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pmod_serial_tx_if #(.WIDTH(9)) bus_a ();
    pmod_serial_tx_if #(.WIDTH(9)) bus_b ();
    pmod_serial_tx_if #(.WIDTH(4)) bus_c ();

    logic a_p1, a_p2, a_p3, a_fd;
    logic b_p1, b_p2, b_p3, b_fd;
    logic c_p1, c_p2, c_p3, c_fd;
    logic [4:0] obs_a, obs_b, obs_c;

    assign obs_a = {bus_a.o_Ready, a_p1, a_p2, a_p3, a_fd};
    assign obs_b = {bus_b.o_Ready, b_p1, b_p2, b_p3, b_fd};
    assign obs_c = {bus_c.o_Ready, c_p1, c_p2, c_p3, c_fd};

    pmod_serial_tx #(.WIDTH(9), .CLKS_PER_BIT(2), .REPEAT(1'b1)) dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .io_Bus(bus_a),
        .o_PMOD_1(a_p1), .o_PMOD_2(a_p2), .o_PMOD_3(a_p3), .o_Frame_Done(a_fd)
    );

    pmod_serial_tx #(.WIDTH(9), .CLKS_PER_BIT(2), .REPEAT(1'b0)) dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .io_Bus(bus_b),
        .o_PMOD_1(b_p1), .o_PMOD_2(b_p2), .o_PMOD_3(b_p3), .o_Frame_Done(b_fd)
    );

    pmod_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .REPEAT(1'b0)) dut_c (
        .i_Clk(clk), .i_Rst_n(rst_n), .io_Bus(bus_c),
        .o_PMOD_1(c_p1), .o_PMOD_2(c_p2), .o_PMOD_3(c_p3), .o_Frame_Done(c_fd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a", 32'(obs_a), 32'h10);
        check("rst_b", 32'(obs_b), 32'h10);
        check("rst_c", 32'(obs_c), 32'h10);
        rst_n = 1'b1;
    endtask

    // {ready, pmod1, pmod2, pmod3, frame_done} for clock k (1-based) of a CLKS_PER_BIT=2 frame
    function automatic logic [4:0] frame_exp(input logic rdy, input logic [8:0] w, input int k);
        int j;
        j = (k - 1) % 18;
        return {rdy, w[j/2], 1'(j < 2), 1'(j % 2 == 0), 1'(j == 17)};
    endfunction

    initial begin
        logic [8:0] w42, w99, w1ff, w5, w3, w1a6;
        logic [3:0] wc;
        w42  = 9'd42;
        w99  = 9'd99;
        w1ff = 9'h1FF;
        w5   = 9'd5;
        w3   = 9'd3;
        w1a6 = 9'h1A6;
        wc   = 4'b1010;
        bus_a.i_Valid = 1'b0; bus_a.i_Data = '0;
        bus_b.i_Valid = 1'b0; bus_b.i_Data = '0;
        bus_c.i_Valid = 1'b0; bus_c.i_Data = '0;

        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("idle_%0d", k), 32'(obs_a), 32'h10);
        end

        bus_a.i_Data = w42;
        bus_a.i_Valid = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            check($sformatf("w42_%0d", k), 32'(obs_a), 32'(frame_exp(k <= 5, w42, k)));
            if (k == 1) bus_a.i_Valid = 1'b0;
            if (k == 5) begin bus_a.i_Data = w99; bus_a.i_Valid = 1'b1; end
            if (k > 5 && k < 18) bus_a.i_Data = 9'(k * 37);
            if (k == 18) bus_a.i_Valid = 1'b0;
        end
        for (int k = 19; k <= 54; k++) begin
            @(negedge clk);
            check($sformatf("w99_%0d", k), 32'(obs_a), 32'(frame_exp(1'b1, w99, k - 18)));
        end

        do_reset();
        bus_a.i_Data = w1ff;
        bus_a.i_Valid = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k <= 7)
                check($sformatf("abort_%0d", k), 32'(obs_a), 32'(frame_exp(1'b1, w1ff, k)));
            else
                check($sformatf("abort_%0d", k), 32'(obs_a), 32'h10);
            if (k == 1) bus_a.i_Valid = 1'b0;
            if (k == 7) rst_n = 1'b0;
            if (k == 9) rst_n = 1'b1;
        end

        do_reset();
        bus_b.i_Data = w5;
        bus_b.i_Valid = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            check($sformatf("once_%0d", k), 32'(obs_b), (k <= 18) ? 32'(frame_exp(1'b1, w5, k)) : 32'h10);
            if (k == 1) bus_b.i_Valid = 1'b0;
        end

        bus_b.i_Data = w3;
        bus_b.i_Valid = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 18)
                check($sformatf("byp_%0d", k), 32'(obs_b), 32'(frame_exp(1'b1, w3, k)));
            else if (k <= 36)
                check($sformatf("byp_%0d", k), 32'(obs_b), 32'(frame_exp(1'b1, w1a6, k - 18)));
            else
                check($sformatf("byp_%0d", k), 32'(obs_b), 32'h10);
            if (k == 1) bus_b.i_Valid = 1'b0;
            if (k == 18) begin bus_b.i_Data = w1a6; bus_b.i_Valid = 1'b1; end
            if (k == 19) bus_b.i_Valid = 1'b0;
        end

        do_reset();
        bus_c.i_Data = wc;
        bus_c.i_Valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4)
                check($sformatf("w4_%0d", k), 32'(obs_c), 32'({1'b1, wc[k-1], 1'(k == 1), 1'b1, 1'(k == 4)}));
            else
                check($sformatf("w4_%0d", k), 32'(obs_c), 32'h10);
            if (k == 1) bus_c.i_Valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmod_serial_tx.md
Name: pmod_serial_tx

Overview:
- Transmit end of the single-wire PMOD serial link consumed by the seven-segment display board.
- Accepts WIDTH-bit words over a valid/ready handshake and serializes them LSB-first on one PMOD pin.
- Each bit is held for CLKS_PER_BIT clocks. Frames are sent back-to-back with no gap, so the receiver's free-running bit counter stays aligned.
- Adds a frame-marker pin and a bit-strobe pin so receivers can resynchronize.

Parameters:
- WIDTH, 9, bits per frame; must be >= 2.
- CLKS_PER_BIT, 2, clocks each bit is held; must be >= 1.
- REPEAT, 1, 1 = retransmit last word continuously when nothing is pending; 0 = go idle.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst_n  input  1  reset, synchronous, active-low.
- i_Data  input  WIDTH  word to transmit.
- i_Valid  input  1  i_Data is valid.
- o_Ready  output  1  pending slot free; a word is accepted on an edge where i_Valid && o_Ready.
- o_PMOD_1  output  1  serial data, LSB first.
- o_PMOD_2  output  1  frame marker; high for the whole bit-0 period of every frame.
- o_PMOD_3  output  1  bit strobe; high in the first clock of every bit period.
- o_Frame_Done  output  1  one-clock pulse in the last clock of every frame.

Behaviour:
- Reset (i_Rst_n low at an edge):
  - State IDLE; shift register, held word, pending slot, bit index and divider all cleared.
  - o_PMOD_1/2/3 = 0, o_Frame_Done = 0, o_Ready = 1.
  - Reset mid-frame aborts the frame: the line is low from the next edge and no partial frame resumes.
- State IDLE:
  - Line outputs are 0.
  - An accept at edge N loads the shift register and held word and enters SEND.
  - bit0 appears on o_PMOD_1 from cycle N+1, with o_PMOD_2 = 1 and o_PMOD_3 = 1 in that cycle.
  - Latency from accept to first bit is 1 clock.
- State SEND:
  - Divider counts 0..CLKS_PER_BIT-1.
  - When the divider wraps, the bit index advances and the shift register shifts right.
  - o_PMOD_1 = shift[0] for the whole period.
  - o_PMOD_2 = (bit index == 0).
  - o_PMOD_3 = (divider == 0).
  - A frame lasts exactly WIDTH*CLKS_PER_BIT clocks.
- Frame end (last clock of bit WIDTH-1; o_Frame_Done = 1). Priority at that edge:
  1. Pending slot full: load pending into shift and held word, clear pending.
  2. Else, an accept on this same edge: load i_Data directly (bypass), pending stays empty.
  3. Else, REPEAT = 1: reload held word.
  4. Else: go to IDLE.
  - Cases 1–3 start the next frame's bit0 on the very next clock (zero gap).
- Accept during SEND (not at frame end): word goes to the pending slot; o_Ready drops the next cycle.
- o_Ready = !pending_full. It is registered, so it is never combinationally dependent on i_Valid.
- If i_Valid is held with o_Ready low, nothing is captured; i_Data may change freely.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - default constants PMOD_WORD_WIDTH = 9 and PMOD_CLKS_PER_BIT = 2, also used by the receiver;
  - state enum {IDLE, SEND}.
- One sub-module: pmod_bit_tick.
  - CLKS_PER_BIT divider with synchronous active-low reset and a clear input.
  - Outputs: first-clock tick (drives o_PMOD_3) and last-clock tick (drives bit advance).
  - Reused by a later receiver rework.

Test Plan:
- Reset release, i_Valid = 0 for 20 clocks -> all line outputs 0, o_Ready = 1, no o_Frame_Done.
- Accept 9'd42 in IDLE (defaults) -> from the next clock, o_PMOD_1 = 0,1,0,1,0,1,0,0,0, each bit held 2 clocks. o_PMOD_2 is high for clocks 1–2 only. o_PMOD_3 pulses every other clock. o_Frame_Done pulses at clock 18.
- Accept 42, then 99 mid-frame -> o_Ready low until clock 18. 99 (1,1,0,0,0,1,1,0,0) starts at clock 19 with no gap. With REPEAT=1 and nothing further, 99 repeats indefinitely.
- REPEAT = 0, accept 5 with i_Valid dropped after -> one 18-clock frame, then return to IDLE with the line low. A second word offered exactly at the frame-end edge is sent with zero gap (bypass path).
- Assert i_Rst_n low at clock 7 of a frame of 9'h1FF -> line 0 from the next edge, o_Ready = 1, no resumption after release.
- CLKS_PER_BIT = 1, WIDTH = 4, accept 4'b1010 -> bits 0,1,0,1 on consecutive clocks. o_PMOD_3 is constantly high during SEND. Frame is 4 clocks.
